// File: rtl/systolic_array_pkg.sv
// Shared types for the systolic-array row loader.
// The loader's optional feature is selected by SA_LOADER_ZERO_PS_EN.
package systolic_array_pkg;

  localparam int SA_N  = 4;
  localparam int SA_DW = 16;
  localparam int ROW_W = $clog2(SA_N);

  typedef logic [ROW_W-1:0]      row_idx_t;
  typedef logic [SA_N*SA_DW-1:0] row_data_t;

  typedef enum logic [3:0] {
    IDLE,
    W_GATE,
    W_RD,
    W_WAIT,
    W_ISSUE,
    I_GATE,
    P_RD,
    P_WAIT,
    I_RD,
    I_WAIT,
    I_ISSUE,
    DONE
  } loader_state_t;

endpackage

// File: rtl/sa_row_fetch.sv
// Single-row scratchpad fetch: one read strobe, then waits for rd_valid.
// Responses that arrive while no read is pending are dropped.
module sa_row_fetch #(
  parameter int AW = 16,
  parameter int W  = 64
) (
  input  logic          clk,
  input  logic          nRST,
  input  logic          start,
  input  logic [AW-1:0] addr,
  output logic          rd_req,
  output logic [AW-1:0] rd_addr,
  input  logic          rd_valid,
  input  logic [W-1:0]  rd_data,
  output logic [W-1:0]  data,
  output logic          fetch_done
);

  logic pend_q;

  assign rd_req     = start;
  assign rd_addr    = start ? addr : '0;
  assign fetch_done = pend_q & rd_valid;
  assign data       = fetch_done ? rd_data : '0;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      pend_q <= 1'b0;
    end else if (start) begin
      pend_q <= 1'b1;
    end else if (fetch_done) begin
      pend_q <= 1'b0;
    end
  end

endmodule

// File: rtl/systolic_array_loader.sv
// Row loader: streams weight, input and partial rows N-1..0 into the array.
// SA_LOADER_ZERO_PS_EN adds req_zero_ps to skip partial-sum reads.
module systolic_array_loader #(
  parameter int N  = 4,
  parameter int DW = 16,
  parameter int AW = 16
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_load_weights,
  input  logic [AW-1:0]        req_w_addr,
  input  logic [AW-1:0]        req_i_addr,
  input  logic [AW-1:0]        req_p_addr,
`ifdef SA_LOADER_ZERO_PS_EN
  input  logic                 req_zero_ps,
`endif
  output logic                 rd_req,
  output logic [AW-1:0]        rd_addr,
  input  logic                 rd_valid,
  input  logic [N*DW-1:0]      rd_data,
  input  logic                 fifo_has_space,
  output logic                 weight_en,
  output logic                 input_en,
  output logic                 partial_en,
  output logic [$clog2(N)-1:0] row_en,
  output logic [N*DW-1:0]      array_in,
  output logic [N*DW-1:0]      array_ps,
  output logic                 busy,
  output logic                 done
);

  import systolic_array_pkg::*;

  localparam int RW = $clog2(N);
  localparam int W  = N * DW;

  loader_state_t state_q, state_d;

  logic [RW-1:0] row_q;
  logic [AW-1:0] w_q, i_q, p_q;
  logic [W-1:0]  data_q, ps_q;
  logic          skip_ps;

  logic          fetch_start;
  logic [AW-1:0] fetch_addr;
  logic [W-1:0]  fetch_data;
  logic          fetch_done;

`ifdef SA_LOADER_ZERO_PS_EN
  logic z_q;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      z_q <= 1'b0;
    end else if (state_q == IDLE && req_valid) begin
      z_q <= req_zero_ps;
    end
  end

  assign skip_ps = z_q;
`else
  assign skip_ps = 1'b0;
`endif

  sa_row_fetch #(
    .AW(AW),
    .W (W)
  ) u_fetch (
    .clk       (clk),
    .nRST      (nRST),
    .start     (fetch_start),
    .addr      (fetch_addr),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .data      (fetch_data),
    .fetch_done(fetch_done)
  );

  always_comb begin
    state_d     = state_q;
    fetch_start = 1'b0;
    fetch_addr  = '0;
    req_ready   = 1'b0;
    weight_en   = 1'b0;
    input_en    = 1'b0;
    partial_en  = 1'b0;
    row_en      = '0;
    array_in    = '0;
    array_ps    = '0;
    busy        = 1'b1;
    done        = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy      = 1'b0;
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = req_load_weights ? W_GATE : I_GATE;
        end
      end
      W_GATE: begin
        if (fifo_has_space) state_d = W_RD;
      end
      W_RD: begin
        fetch_start = 1'b1;
        fetch_addr  = w_q + AW'(row_q);
        state_d     = W_WAIT;
      end
      W_WAIT: begin
        if (fetch_done) state_d = W_ISSUE;
      end
      W_ISSUE: begin
        weight_en = 1'b1;
        row_en    = row_q;
        array_in  = data_q;
        state_d   = (row_q == '0) ? I_GATE : W_RD;
      end
      I_GATE: begin
        if (fifo_has_space) state_d = skip_ps ? I_RD : P_RD;
      end
      P_RD: begin
        fetch_start = 1'b1;
        fetch_addr  = p_q + AW'(row_q);
        state_d     = P_WAIT;
      end
      P_WAIT: begin
        if (fetch_done) state_d = I_RD;
      end
      I_RD: begin
        fetch_start = 1'b1;
        fetch_addr  = i_q + AW'(row_q);
        state_d     = I_WAIT;
      end
      I_WAIT: begin
        if (fetch_done) state_d = I_ISSUE;
      end
      I_ISSUE: begin
        input_en   = 1'b1;
        partial_en = 1'b1;
        row_en     = row_q;
        array_in   = data_q;
        array_ps   = skip_ps ? '0 : ps_q;
        if (row_q == '0) begin
          state_d = DONE;
        end else begin
          state_d = skip_ps ? I_RD : P_RD;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      row_q   <= RW'(N-1);
      w_q     <= '0;
      i_q     <= '0;
      p_q     <= '0;
      data_q  <= '0;
      ps_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req_valid) begin
        w_q   <= req_w_addr;
        i_q   <= req_i_addr;
        p_q   <= req_p_addr;
        row_q <= RW'(N-1);
      end
      // The weight phase rewinds the counter for the input phase.
      if (state_q == W_ISSUE) begin
        row_q <= (row_q == '0) ? RW'(N-1) : row_q - RW'(1);
      end
      if (state_q == I_ISSUE && row_q != '0) begin
        row_q <= row_q - RW'(1);
      end
      if (fetch_done) begin
        if (state_q == P_WAIT) ps_q <= fetch_data;
        else                   data_q <= fetch_data;
      end
    end
  end

endmodule

// File: tb/tb_systolic_array_loader.sv
// Directed self-checking bench for systolic_array_loader.
// Covers SA_LOADER_ZERO_PS_EN when that macro is defined.
module tb_systolic_array_loader;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int W  = N * DW;

  localparam logic [AW-1:0] WB = 16'hFFFE;
  localparam logic [AW-1:0] IB = 16'h0100;
  localparam logic [AW-1:0] PB = 16'h0200;

  typedef struct {
    bit            w;
    int            row;
    logic [W-1:0]  ai;
    logic [W-1:0]  ap;
    int            cyc;
  } ev_t;

  logic          clk;
  logic          nRST;
  logic          req_valid;
  logic          req_ready;
  logic          req_load_weights;
  logic [AW-1:0] req_w_addr;
  logic [AW-1:0] req_i_addr;
  logic [AW-1:0] req_p_addr;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [W-1:0]  rd_data;
  logic          fifo_has_space;
  logic          weight_en;
  logic          input_en;
  logic          partial_en;
  logic [1:0]    row_en;
  logic [W-1:0]  array_in;
  logic [W-1:0]  array_ps;
  logic          busy;
  logic          done;
`ifdef SA_LOADER_ZERO_PS_EN
  logic          zero_ps;
`endif

  logic          resp_valid;
  logic [W-1:0]  resp_data;
  logic          stray_valid;

  int lat   = 1;
  int cyc   = 0;
  int viol  = 0;
  int n_cmp = 0;
  int n_err = 0;

  ev_t           ev_q[$];
  int            done_q[$];
  logic [AW-1:0] rd_q[$];

  assign rd_valid = resp_valid | stray_valid;
  assign rd_data  = stray_valid ? {4{16'hBAD0}} : resp_data;

  systolic_array_loader #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk             (clk),
    .nRST            (nRST),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_load_weights(req_load_weights),
    .req_w_addr      (req_w_addr),
    .req_i_addr      (req_i_addr),
    .req_p_addr      (req_p_addr),
`ifdef SA_LOADER_ZERO_PS_EN
    .req_zero_ps     (zero_ps),
`endif
    .rd_req          (rd_req),
    .rd_addr         (rd_addr),
    .rd_valid        (rd_valid),
    .rd_data         (rd_data),
    .fifo_has_space  (fifo_has_space),
    .weight_en       (weight_en),
    .input_en        (input_en),
    .partial_en      (partial_en),
    .row_en          (row_en),
    .array_in        (array_in),
    .array_ps        (array_ps),
    .busy            (busy),
    .done            (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] mem(input logic [AW-1:0] a);
    logic [AW-1:0] s;
    s = a + 16'h1111;
    return {a ^ 16'h5A5A, s, ~a, a[7:0], a[15:8]};
  endfunction

  // Scratchpad model: answers each strobe after lat cycles (lat 0 = random 1..5).
  initial begin
    logic [AW-1:0] a;
    int d;
    resp_valid = 1'b0;
    resp_data  = '0;
    forever begin
      @(negedge clk);
      if (rd_req === 1'b1) begin
        a = rd_addr;
        d = (lat == 0) ? int'($urandom_range(1, 5)) : lat;
        repeat (d - 1) @(negedge clk);
        @(posedge clk);
        #1;
        resp_valid = 1'b1;
        resp_data  = mem(a);
        @(posedge clk);
        #1;
        resp_valid = 1'b0;
        resp_data  = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (weight_en || input_en)
      ev_q.push_back('{weight_en, int'(row_en), array_in, array_ps, cyc});
    if (done) done_q.push_back(cyc);
    if (rd_req) rd_q.push_back(rd_addr);
    if (weight_en && input_en) viol++;
    if (partial_en !== input_en) viol++;
    if (!weight_en && !input_en &&
        (row_en != 0 || array_in != 0 || array_ps != 0)) viol++;
    if (weight_en && array_ps != 0) viol++;
  end

  task automatic start_req(input bit lw, input logic [AW-1:0] wb,
                           input logic [AW-1:0] ib, input logic [AW-1:0] pb);
    @(posedge clk);
    #1;
    req_valid        = 1'b1;
    req_load_weights = lw;
    req_w_addr       = wb;
    req_i_addr       = ib;
    req_p_addr       = pb;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int db, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      #1;
      ok = (done_q.size() > db);
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got %b want 1", req_ready);
    end
    n_cmp++;
    if ({busy, done, rd_req, weight_en, input_en, partial_en} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {busy, done, rd_req, weight_en, input_en, partial_en});
    end
    n_cmp++;
    if ({row_en, rd_addr, array_in, array_ps} !== '0) begin
      n_err++;
      $display("FAIL reset_bus: got %h want 0", {row_en, rd_addr, array_in, array_ps});
    end
    @(posedge clk);
    #2;
    nRST = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({req_ready, busy} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_release: got %b want 10", {req_ready, busy});
    end
  endtask

  task automatic test_full();
    int b, rb, db, r, g, ne;
    bit ok;
    ev_t e;
    logic [AW-1:0] a;
    logic [W-1:0] ap;
    b = ev_q.size(); rb = rd_q.size(); db = done_q.size();
    lat = 1;
    start_req(1'b1, WB, IB, PB);
    wait_done(db, 200, ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL full_done: got %b want 1", ok);
    end
    ne = ev_q.size() - b;
    n_cmp++;
    if (ne !== 8) begin
      n_err++;
      $display("FAIL full_count: got %0d want 8", ne);
    end else begin
      for (int k = 0; k < 8; k++) begin
        e  = ev_q[b + k];
        r  = 3 - (k % 4);
        a  = (k < 4) ? WB + AW'(r) : IB + AW'(r);
        ap = (k < 4) ? '0 : mem(PB + AW'(r));
        n_cmp++;
        if (e.w !== (k < 4) || e.row !== r || e.ai !== mem(a) || e.ap !== ap) begin
          n_err++;
          $display("FAIL full_ev%0d: got w%0b r%0d %h %h want w%0b r%0d %h %h",
                   k, e.w, e.row, e.ai, e.ap, k < 4, r, mem(a), ap);
        end
        if (k > 0) begin
          g = (k < 4) ? 3 : ((k == 4) ? 6 : 5);
          n_cmp++;
          if (e.cyc - ev_q[b + k - 1].cyc !== g) begin
            n_err++;
            $display("FAIL full_gap%0d: got %0d want %0d",
                     k, e.cyc - ev_q[b + k - 1].cyc, g);
          end
        end
      end
    end
    n_cmp++;
    if (rd_q.size() - rb !== 12) begin
      n_err++;
      $display("FAIL full_reads: got %0d want 12", rd_q.size() - rb);
    end else begin
      n_cmp++;
      if ({rd_q[rb], rd_q[rb + 4], rd_q[rb + 5]} !== {16'h0001, PB + 16'd3, IB + 16'd3}) begin
        n_err++;
        $display("FAIL full_addr: got %h %h %h want 0001 %h %h",
                 rd_q[rb], rd_q[rb + 4], rd_q[rb + 5], PB + 16'd3, IB + 16'd3);
      end
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({req_ready, busy} !== 2'b10 || done_q.size() - db !== 1) begin
      n_err++;
      $display("FAIL full_end: got rdy%b busy%b dones%0d want 1 0 1",
               req_ready, busy, done_q.size() - db);
    end
  endtask

  task automatic test_no_weights();
    int b, rb, db, r, ne;
    bit ok;
    ev_t e;
    logic [AW-1:0] a;
    b = ev_q.size(); rb = rd_q.size(); db = done_q.size();
    lat = 1;
    start_req(1'b0, WB, IB, PB);
    wait_done(db, 200, ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL nw_done: got %b want 1", ok);
    end
    n_cmp++;
    if (rd_q.size() - rb !== 8) begin
      n_err++;
      $display("FAIL nw_reads: got %0d want 8", rd_q.size() - rb);
    end else begin
      for (int k = 0; k < 8; k++) begin
        r = 3 - k / 2;
        a = (k % 2 == 0) ? PB + AW'(r) : IB + AW'(r);
        n_cmp++;
        if (rd_q[rb + k] !== a) begin
          n_err++;
          $display("FAIL nw_addr%0d: got %h want %h", k, rd_q[rb + k], a);
        end
      end
    end
    ne = ev_q.size() - b;
    n_cmp++;
    if (ne !== 4) begin
      n_err++;
      $display("FAIL nw_count: got %0d want 4", ne);
    end else begin
      for (int k = 0; k < 4; k++) begin
        e = ev_q[b + k];
        r = 3 - k;
        n_cmp++;
        if (e.w !== 1'b0 || e.row !== r || e.ai !== mem(IB + AW'(r)) ||
            e.ap !== mem(PB + AW'(r))) begin
          n_err++;
          $display("FAIL nw_ev%0d: got w%0b r%0d %h %h want w0 r%0d %h %h",
                   k, e.w, e.row, e.ai, e.ap, r, mem(IB + AW'(r)), mem(PB + AW'(r)));
        end
      end
    end
  endtask

  task automatic test_fifo_gate();
    int b, rb, db, nb, ne;
    bit ok, hit;
    b = ev_q.size(); rb = rd_q.size(); db = done_q.size();
    lat = 1;
    fifo_has_space = 1'b0;
    start_req(1'b0, WB, IB, PB);
    nb = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b1) nb++;
    end
    n_cmp++;
    if (rd_q.size() - rb !== 0 || nb !== 0) begin
      n_err++;
      $display("FAIL gate_hold: got reads%0d notbusy%0d want 0 0", rd_q.size() - rb, nb);
    end
    @(posedge clk);
    #1;
    fifo_has_space = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (rd_req !== 1'b1 || rd_addr !== PB + 16'd3) begin
      n_err++;
      $display("FAIL gate_open: got %b %h want 1 %h", rd_req, rd_addr, PB + 16'd3);
    end
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      #1;
      hit = (ev_q.size() - b >= 1);
    end
    fifo_has_space = 1'b0;
    wait_done(db, 200, ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL gate_done: got %b want 1", ok);
    end
    ne = ev_q.size() - b;
    n_cmp++;
    if (ne !== 4) begin
      n_err++;
      $display("FAIL gate_count: got %0d want 4", ne);
    end else begin
      for (int k = 1; k < 4; k++) begin
        n_cmp++;
        if (ev_q[b + k].cyc - ev_q[b + k - 1].cyc !== 5) begin
          n_err++;
          $display("FAIL gate_gap%0d: got %0d want 5",
                   k, ev_q[b + k].cyc - ev_q[b + k - 1].cyc);
        end
      end
    end
    fifo_has_space = 1'b1;
  endtask

  task automatic test_latency();
    int b, rb, db, r, ne, g;
    bit ok;
    ev_t e;
    logic [AW-1:0] a;
    logic [W-1:0] ap;
    b = ev_q.size(); db = done_q.size();
    lat = 3;
    start_req(1'b1, WB, IB, PB);
    wait_done(db, 400, ok);
    ne = ev_q.size() - b;
    n_cmp++;
    if (ok !== 1'b1 || ne !== 8) begin
      n_err++;
      $display("FAIL l3_run: got done%b events%0d want 1 8", ok, ne);
    end else begin
      for (int k = 1; k < 8; k++) begin
        if (k != 4) begin
          g = (k < 4) ? 5 : 9;
          n_cmp++;
          if (ev_q[b + k].cyc - ev_q[b + k - 1].cyc !== g) begin
            n_err++;
            $display("FAIL l3_gap%0d: got %0d want %0d",
                     k, ev_q[b + k].cyc - ev_q[b + k - 1].cyc, g);
          end
        end
      end
    end
    b = ev_q.size(); rb = rd_q.size(); db = done_q.size();
    lat = 0;
    fifo_has_space = 1'b0;
    start_req(1'b1, WB, IB, PB);
    @(posedge clk);
    #1;
    stray_valid = 1'b1;
    @(posedge clk);
    #1;
    stray_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rd_q.size() - rb !== 0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL stray_gate: got reads%0d busy%b want 0 1", rd_q.size() - rb, busy);
    end
    @(posedge clk);
    #1;
    fifo_has_space = 1'b1;
    wait_done(db, 600, ok);
    ne = ev_q.size() - b;
    n_cmp++;
    if (ok !== 1'b1 || ne !== 8) begin
      n_err++;
      $display("FAIL rnd_run: got done%b events%0d want 1 8", ok, ne);
    end else begin
      for (int k = 0; k < 8; k++) begin
        e  = ev_q[b + k];
        r  = 3 - (k % 4);
        a  = (k < 4) ? WB + AW'(r) : IB + AW'(r);
        ap = (k < 4) ? '0 : mem(PB + AW'(r));
        n_cmp++;
        if (e.w !== (k < 4) || e.row !== r || e.ai !== mem(a) || e.ap !== ap) begin
          n_err++;
          $display("FAIL rnd_ev%0d: got w%0b r%0d %h %h want w%0b r%0d %h %h",
                   k, e.w, e.row, e.ai, e.ap, k < 4, r, mem(a), ap);
        end
      end
    end
    lat = 1;
  endtask

  task automatic test_reset_mid();
    int b, rb, db, r, ne;
    bit ok, hit;
    ev_t e;
    logic [AW-1:0] a;
    logic [W-1:0] ap;
    b = ev_q.size(); db = done_q.size();
    lat = 3;
    start_req(1'b1, WB, IB, PB);
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      #1;
      hit = (ev_q.size() - b >= 6);
    end
    n_cmp++;
    if (hit !== 1'b1) begin
      n_err++;
      $display("FAIL rst_reach: got %b want 1", hit);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (rd_req !== 1'b1 || rd_addr !== PB + 16'd1) begin
      n_err++;
      $display("FAIL rst_pre: got %b %h want 1 %h", rd_req, rd_addr, PB + 16'd1);
    end
    #5;
    nRST = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready, busy, done, rd_req, weight_en, input_en, partial_en} !== 7'b1000000 ||
        {row_en, rd_addr, array_in, array_ps} !== '0) begin
      n_err++;
      $display("FAIL rst_async: got %b %h want 1000000 0",
               {req_ready, busy, done, rd_req, weight_en, input_en, partial_en},
               {row_en, rd_addr, array_in, array_ps});
    end
    b = ev_q.size(); rb = rd_q.size(); db = done_q.size();
    @(posedge clk);
    #3;
    nRST = 1'b1;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (ev_q.size() - b !== 0 || rd_q.size() - rb !== 0 || done_q.size() - db !== 0 ||
        {req_ready, busy} !== 2'b10) begin
      n_err++;
      $display("FAIL rst_quiet: got ev%0d rd%0d dn%0d rdy%b busy%b want 0 0 0 1 0",
               ev_q.size() - b, rd_q.size() - rb, done_q.size() - db, req_ready, busy);
    end
    lat = 1;
    start_req(1'b1, 16'h0300, 16'h0400, 16'h0500);
    wait_done(db, 200, ok);
    ne = ev_q.size() - b;
    n_cmp++;
    if (ok !== 1'b1 || ne !== 8) begin
      n_err++;
      $display("FAIL rst_rerun: got done%b events%0d want 1 8", ok, ne);
    end else begin
      for (int k = 0; k < 8; k++) begin
        e  = ev_q[b + k];
        r  = 3 - (k % 4);
        a  = (k < 4) ? 16'h0300 + AW'(r) : 16'h0400 + AW'(r);
        ap = (k < 4) ? '0 : mem(16'h0500 + AW'(r));
        n_cmp++;
        if (e.w !== (k < 4) || e.row !== r || e.ai !== mem(a) || e.ap !== ap) begin
          n_err++;
          $display("FAIL rerun_ev%0d: got w%0b r%0d %h %h want w%0b r%0d %h %h",
                   k, e.w, e.row, e.ai, e.ap, k < 4, r, mem(a), ap);
        end
      end
    end
  endtask

`ifdef SA_LOADER_ZERO_PS_EN
  task automatic test_zero_ps();
    int b, rb, db, r, ne;
    bit ok;
    ev_t e;
    b = ev_q.size(); rb = rd_q.size(); db = done_q.size();
    lat = 1;
    zero_ps = 1'b1;
    start_req(1'b0, WB, IB, PB);
    zero_ps = 1'b0;
    wait_done(db, 200, ok);
    n_cmp++;
    if (ok !== 1'b1 || rd_q.size() - rb !== 4) begin
      n_err++;
      $display("FAIL zps_run: got done%b reads%0d want 1 4", ok, rd_q.size() - rb);
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_cmp++;
        if (rd_q[rb + k] !== IB + AW'(3 - k)) begin
          n_err++;
          $display("FAIL zps_addr%0d: got %h want %h", k, rd_q[rb + k], IB + AW'(3 - k));
        end
      end
    end
    ne = ev_q.size() - b;
    n_cmp++;
    if (ne !== 4) begin
      n_err++;
      $display("FAIL zps_count: got %0d want 4", ne);
    end else begin
      for (int k = 0; k < 4; k++) begin
        e = ev_q[b + k];
        r = 3 - k;
        n_cmp++;
        if (e.row !== r || e.ai !== mem(IB + AW'(r)) || e.ap !== '0) begin
          n_err++;
          $display("FAIL zps_ev%0d: got r%0d %h %h want r%0d %h 0",
                   k, e.row, e.ai, e.ap, r, mem(IB + AW'(r)));
        end
        if (k > 0) begin
          n_cmp++;
          if (e.cyc - ev_q[b + k - 1].cyc !== 3) begin
            n_err++;
            $display("FAIL zps_gap%0d: got %0d want 3", k, e.cyc - ev_q[b + k - 1].cyc);
          end
        end
      end
    end
  endtask
`endif

  task automatic test_invariants();
    n_cmp++;
    if (viol !== 0) begin
      n_err++;
      $display("FAIL invariants: got %0d violations want 0", viol);
    end
  endtask

  initial begin
    nRST             = 1'b0;
    req_valid        = 1'b0;
    req_load_weights = 1'b0;
    req_w_addr       = '0;
    req_i_addr       = '0;
    req_p_addr       = '0;
    fifo_has_space   = 1'b1;
    stray_valid      = 1'b0;
`ifdef SA_LOADER_ZERO_PS_EN
    zero_ps          = 1'b0;
`endif
    test_reset();
    test_full();
    test_no_weights();
    test_fifo_gate();
    test_latency();
    test_reset_mid();
`ifdef SA_LOADER_ZERO_PS_EN
    test_zero_ps();
`endif
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/systolic_array_loader.md
Name: systolic_array_loader

Overview:
- Sender side of the systolic-array control unit's row-load interface.
- Accepts one matrix-op request, reads weight, input and partial-sum rows from a scratchpad read port, and drives them into the array FIFOs one row per pulse using weight_en/input_en/partial_en/row_en.
- Rows are issued from N-1 down to 0. The control unit starts an iteration on the input pulse for row 0, so row 0 must be the last row issued.

Parameters:
- N, 4: array dimension; rows per matrix.
- DW, 16: element width in bits.
- AW, 16: scratchpad row-address width.

Ports:
- clk  in  1  clock.
- nRST  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request valid.
- req_ready  out  1  high only in IDLE.
- req_load_weights  in  1  run the weight phase first.
- req_w_addr  in  AW  weight matrix base; row r is at base+r.
- req_i_addr  in  AW  input matrix base.
- req_p_addr  in  AW  partial-sum matrix base.
- rd_req  out  1  scratchpad read strobe, one-cycle pulse.
- rd_addr  out  AW  scratchpad read address.
- rd_valid  in  1  read data valid; arrives 1 or more cycles after rd_req.
- rd_data  in  N*DW  read data.
- fifo_has_space  in  1  from control unit.
- weight_en  out  1  weight row pulse.
- input_en  out  1  input row pulse.
- partial_en  out  1  partial row pulse; always coincident with input_en.
- row_en  out  $clog2(N)  row index of the current pulse.
- array_in  out  N*DW  input or weight row data.
- array_ps  out  N*DW  partial row data.
- busy  out  1  high when not in IDLE.
- done  out  1  one-cycle pulse after the row-0 input pulse.

Behaviour:
- Reset: all outputs are 0 except req_ready, which is 1. FSM goes to IDLE, row counter to N-1, data registers to 0.
- Reset mid-operation aborts immediately. No pulses are issued until a new request.
- Accept: on req_valid && req_ready, capture all req_* fields and set row=N-1.
  - Next state is W_GATE if req_load_weights, else I_GATE.
- W_GATE / I_GATE: wait for fifo_has_space==1, then go to W_RD / P_RD.
  - Space is checked once per phase.
  - A later drop of fifo_has_space does not stall a phase already in progress.
- W_RD: rd_req=1, rd_addr=w_base+row for one cycle, then W_WAIT.
- W_WAIT: on rd_valid, register rd_data into the weight/input data register, then W_ISSUE.
- W_ISSUE, one cycle: weight_en=1, row_en=row, array_in=data register.
  - If row==0: row=N-1, go to I_GATE.
  - Else: row-1, go to W_RD.
- P_RD → P_WAIT: read p_base+row; capture into the partial register on rd_valid.
- I_RD → I_WAIT: read i_base+row; capture into the data register on rd_valid.
- I_ISSUE, one cycle: input_en=1, partial_en=1, row_en=row, array_in=data register, array_ps=partial register.
  - If row==0: go to DONE.
  - Else: row-1, go to P_RD.
- DONE: done=1 for one cycle, then IDLE.
- Outside issue cycles, all *_en are 0; row_en and array buses are 0.
- weight_en and input_en are never high in the same cycle.
- Only one read is outstanding at a time.
  - rd_valid is ignored outside *_WAIT states, e.g. a stale response after reset.
- Same-cycle rd_req and rd_valid is illegal; the bench never drives it.
- Address arithmetic is modulo 2^AW; a base near the top wraps.
- Per-row cycle cost with read latency L:
  - Weight row: L+2 cycles.
  - Input row: 2L+3 cycles.

Optional Feature:
- Macro: SA_LOADER_ZERO_PS_EN.
- Defined: adds input port req_zero_ps (1 bit), captured with the request.
  - When set, P_RD/P_WAIT are skipped: I_ISSUE → I_RD directly, and I_GATE → I_RD.
  - array_ps=0 while partial_en is still pulsed.
  - Input row cost becomes L+2.
- Undefined: the port is absent and partials are always read.

Decomposition:
- Package systolic_array_pkg holds:
  - loader_state_t enum: IDLE, W_GATE, W_RD, W_WAIT, W_ISSUE, I_GATE, P_RD, P_WAIT, I_RD, I_WAIT, I_ISSUE, DONE.
  - ROW_W=$clog2(N) and typedef row_idx_t.
  - typedef row_data_t = logic [N*DW-1:0].
- One natural sub-module: sa_row_fetch. It issues a single scratchpad read, waits for rd_valid, and presents the captured data with a fetch_done strobe. It is instantiated once and sequenced by the loader FSM.

Test Plan:
- N=4, L=1, fifo_has_space=1, load_weights=1:
  - Weight pulses at rows 3,2,1,0, 3 cycles apart.
  - Then 4 input+partial pulses at rows 3,2,1,0, 5 cycles apart.
  - array_in/array_ps equal the scratchpad contents at base+row.
  - done pulses once; req_ready returns to 1.
- load_weights=0: no weight_en pulses and no reads of w_addr; the first read is p_base+3.
- Hold fifo_has_space=0 for 20 cycles at I_GATE: no rd_req and busy=1. Raise it: P_RD occurs the next cycle.
  - Dropping fifo_has_space mid-phase does not delay the remaining rows.
- L=3 and a random rd_valid delay of 1–5 cycles: row order and data are unchanged. A stray rd_valid in W_GATE is ignored.
- Assert nRST after the row-2 input pulse:
  - All outputs go to 0 asynchronously.
  - A late rd_valid is ignored.
  - A new request then runs to completion with correct data.
- With SA_LOADER_ZERO_PS_EN and req_zero_ps=1: no p_addr reads, array_ps=0 on every partial_en, input pulses 3 cycles apart at L=1.
